// File: rtl/dla_axi4_sub_pkg.sv
// ---------------------------------------------------------------------------
// dla_axi4_pkg : shared AXI4 response codes and channel FSM state encodings
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dla_axi4_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      B_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Bursts are never serviced, so a non-zero length outranks a bad address.
   function automatic resp_t resp_code(input logic [7:0] len, input logic in_range);
      if (len != 8'd0)
         return SLVERR;
      else if (!in_range)
         return DECERR;
      else
         return OKAY;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dla_axi4_sub_if.sv
// ---------------------------------------------------------------------------
// AXI_BUS : AXI4 channel bundle with Master/Slave modports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface AXI_BUS #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic                        aw_valid;
   logic                        aw_ready;
   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic                        w_valid;
   logic                        w_ready;
   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic                        b_valid;
   logic                        b_ready;
   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic                        ar_valid;
   logic                        ar_ready;
   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic                        r_valid;
   logic                        r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_valid, input aw_ready,
      output w_data, w_strb, w_last, w_valid, input w_ready,
      input b_id, b_resp, b_valid, output b_ready,
      output ar_id, ar_addr, ar_len, ar_valid, input ar_ready,
      input r_id, r_data, r_resp, r_last, r_valid, output r_ready
   );

   modport Slave (
      input aw_id, aw_addr, aw_len, aw_valid, output aw_ready,
      input w_data, w_strb, w_last, w_valid, output w_ready,
      output b_id, b_resp, b_valid, input b_ready,
      input ar_id, ar_addr, ar_len, ar_valid, output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid, input r_ready
   );

endinterface

`default_nettype wire

// File: rtl/dla_axi4_sub_regbank.sv
// ---------------------------------------------------------------------------
// dla_axi4_sub_regbank : word bank, byte-strobed sync write, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dla_axi4_sub_regbank #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int NUM_REGS       = 16
) (
   input  wire logic                          clk_i,
   input  wire logic                          rstn_i,
   input  wire logic                          i_we,
   input  wire logic [$clog2(NUM_REGS)-1:0]   i_widx,
   input  wire logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
   input  wire logic [AXI_DATA_WIDTH-1:0]     i_wdata,
   input  wire logic [$clog2(NUM_REGS)-1:0]   i_ridx,
   output logic      [AXI_DATA_WIDTH-1:0]     o_rdata
);
   localparam int c_NBYTES = AXI_DATA_WIDTH / 8;

   logic [AXI_DATA_WIDTH-1:0] r_mem [NUM_REGS];

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_mem[i] <= '0;
      end else if (i_we) begin
         for (int b = 0; b < c_NBYTES; b++)
            if (i_wstrb[b])
               r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/dla_axi4_sub.sv
// ---------------------------------------------------------------------------
// dla_axi4_sub : non-pipelined AXI4 subordinate over a register bank
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dla_axi4_sub
   import dla_axi4_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int NUM_REGS       = 16
) (
   input  wire logic                        clk_i,
   input  wire logic                        rstn_i,
   output logic                             wr_evt_o,
   output logic [$clog2(NUM_REGS)-1:0]      wr_idx_o,
   AXI_BUS.Slave                            pp_if
);
   localparam int c_OFFS = $clog2(AXI_DATA_WIDTH / 8);
   localparam int c_IDXW = $clog2(NUM_REGS);
   localparam logic [AXI_ADDR_WIDTH-1:0] c_LIMIT = AXI_ADDR_WIDTH'(NUM_REGS * (AXI_DATA_WIDTH / 8));

   wr_state_t                  r_wst, w_wst_nxt;
   logic [AXI_ADDR_WIDTH-1:0]  r_aw_addr;
   logic [AXI_ID_WIDTH-1:0]    r_aw_id, r_b_id;
   logic [7:0]                 r_aw_len;
   logic                       r_aw_ready, r_w_ready, r_b_valid, r_wr_evt;
   resp_t                      r_b_resp, w_wcode;
   logic [c_IDXW-1:0]          r_wr_idx, w_widx;
   logic                       w_aw_hs, w_w_hs, w_b_hs, w_we;

   rd_state_t                  r_rst, w_rst_nxt;
   logic                       r_ar_ready, r_r_valid, r_r_last;
   logic [AXI_DATA_WIDTH-1:0]  r_r_data, w_bank_rdata;
   resp_t                      r_r_resp, w_rcode;
   logic [AXI_ID_WIDTH-1:0]    r_r_id;
   logic [7:0]                 r_cnt;
   logic [c_IDXW-1:0]          w_ridx;
   logic                       w_ar_hs, w_r_hs;

   assign w_aw_hs = pp_if.aw_valid & r_aw_ready;
   assign w_w_hs  = pp_if.w_valid & r_w_ready;
   assign w_b_hs  = r_b_valid & pp_if.b_ready;
   assign w_wcode = resp_code(r_aw_len, r_aw_addr < c_LIMIT);
   assign w_widx  = r_aw_addr[c_OFFS +: c_IDXW];
   assign w_we    = w_w_hs && (w_wcode == OKAY);

   assign w_ar_hs = pp_if.ar_valid & r_ar_ready;
   assign w_r_hs  = r_r_valid & pp_if.r_ready;
   assign w_rcode = resp_code(pp_if.ar_len, pp_if.ar_addr < c_LIMIT);
   assign w_ridx  = pp_if.ar_addr[c_OFFS +: c_IDXW];

   dla_axi4_sub_regbank #(
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .NUM_REGS       (NUM_REGS)
   ) u_bank (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .i_we    (w_we),
      .i_widx  (w_widx),
      .i_wstrb (pp_if.w_strb),
      .i_wdata (pp_if.w_data),
      .i_ridx  (w_ridx),
      .o_rdata (w_bank_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_wst <= W_IDLE;
         r_rst <= R_IDLE;
      end else begin
         r_wst <= w_wst_nxt;
         r_rst <= w_rst_nxt;
      end
   end

   always_comb begin
      w_wst_nxt = r_wst;
      case (r_wst)
         W_IDLE:  if (w_aw_hs) w_wst_nxt = W_DATA;
         W_DATA:  if (w_w_hs && pp_if.w_last) w_wst_nxt = B_RESP;
         B_RESP:  if (w_b_hs) w_wst_nxt = W_IDLE;
         default: w_wst_nxt = W_IDLE;
      endcase
      w_rst_nxt = r_rst;
      case (r_rst)
         R_IDLE:  if (w_ar_hs) w_rst_nxt = R_DATA;
         R_DATA:  if (w_r_hs && (r_cnt == 8'd0)) w_rst_nxt = R_IDLE;
         default: w_rst_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_aw_addr  <= '0;
         r_aw_id    <= '0;
         r_aw_len   <= '0;
         r_aw_ready <= 1'b1;
         r_w_ready  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_b_resp   <= OKAY;
         r_b_id     <= '0;
         r_wr_evt   <= 1'b0;
         r_wr_idx   <= '0;
      end else begin
         r_wr_evt <= w_we;
         if (w_we)
            r_wr_idx <= w_widx;
         if (w_aw_hs) begin
            r_aw_addr  <= pp_if.aw_addr;
            r_aw_id    <= pp_if.aw_id;
            r_aw_len   <= pp_if.aw_len;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b1;
         end
         if (w_w_hs && pp_if.w_last) begin
            r_w_ready <= 1'b0;
            r_b_valid <= 1'b1;
            r_b_id    <= r_aw_id;
            r_b_resp  <= w_wcode;
         end
         if (w_b_hs) begin
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
         end
      end
   end

   // First beat samples the bank before any same-edge write lands.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_ar_ready <= 1'b1;
         r_r_valid  <= 1'b0;
         r_r_data   <= '0;
         r_r_resp   <= OKAY;
         r_r_last   <= 1'b0;
         r_r_id     <= '0;
         r_cnt      <= '0;
      end else if (w_ar_hs) begin
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b1;
         r_r_id     <= pp_if.ar_id;
         r_r_resp   <= w_rcode;
         r_r_data   <= (w_rcode == OKAY) ? w_bank_rdata : '0;
         r_r_last   <= (pp_if.ar_len == 8'd0);
         r_cnt      <= pp_if.ar_len;
      end else if (w_r_hs) begin
         if (r_cnt == 8'd0) begin
            r_r_valid  <= 1'b0;
            r_ar_ready <= 1'b1;
         end else begin
            r_cnt    <= r_cnt - 8'd1;
            r_r_data <= '0;
            r_r_resp <= SLVERR;
            r_r_last <= (r_cnt == 8'd1);
         end
      end
   end

   assign pp_if.aw_ready = r_aw_ready;
   assign pp_if.w_ready  = r_w_ready;
   assign pp_if.b_valid  = r_b_valid;
   assign pp_if.b_resp   = r_b_resp;
   assign pp_if.b_id     = r_b_id;
   assign pp_if.ar_ready = r_ar_ready;
   assign pp_if.r_valid  = r_r_valid;
   assign pp_if.r_data   = r_r_data;
   assign pp_if.r_resp   = r_r_resp;
   assign pp_if.r_last   = r_r_last;
   assign pp_if.r_id     = r_r_id;
   assign wr_evt_o       = r_wr_evt;
   assign wr_idx_o       = r_wr_idx;

endmodule

`default_nettype wire

// File: tb/tb_dla_axi4_sub.sv
// ---------------------------------------------------------------------------
// tb_dla_axi4_sub : directed scoreboard bench for dla_axi4_sub
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dla_axi4_sub;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
   } b_exp_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } r_exp_t;

   logic       clk;
   logic       rstn;
   logic       wr_evt;
   logic [3:0] wr_idx;

   int n_checks = 0;
   int n_fail   = 0;

   b_exp_t     exp_b[$];
   r_exp_t     exp_r[$];
   logic [3:0] exp_evt[$];
   b_exp_t     eb;
   r_exp_t     er;
   logic [3:0] ei;

   AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) bus ();

   dla_axi4_sub #(
      .AXI_ADDR_WIDTH (32),
      .AXI_DATA_WIDTH (64),
      .AXI_ID_WIDTH   (4),
      .NUM_REGS       (16)
   ) dut (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .wr_evt_o (wr_evt),
      .wr_idx_o (wr_idx),
      .pp_if    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur as expected", name);
   endtask

   // Scoreboard monitor: pops one expectation per observed handshake/pulse.
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.b_valid && bus.b_ready) begin
            if (exp_b.size() == 0) fail_msg("b_unexpected");
            else begin
               eb = exp_b.pop_front();
               chk("b_resp", 64'(bus.b_resp), 64'(eb.resp));
               chk("b_id", 64'(bus.b_id), 64'(eb.id));
            end
         end
         if (bus.r_valid && bus.r_ready) begin
            if (exp_r.size() == 0) fail_msg("r_unexpected");
            else begin
               er = exp_r.pop_front();
               chk("r_data", bus.r_data, er.data);
               chk("r_resp", 64'(bus.r_resp), 64'(er.resp));
               chk("r_last", 64'(bus.r_last), 64'(er.last));
               chk("r_id", 64'(bus.r_id), 64'(er.id));
            end
         end
         if (wr_evt) begin
            if (exp_evt.size() == 0) fail_msg("wr_evt_unexpected");
            else begin
               ei = exp_evt.pop_front();
               chk("wr_idx", 64'(wr_idx), 64'(ei));
            end
         end
      end
   end

   // ch: 0 aw, 1 w, 2 b, 3 ar, 4 last r beat
   task automatic wait_hs(input int ch, input string name);
      bit ok = 1'b0;
      int n  = 0;
      while (!ok && n < 64) begin
         @(negedge clk);
         case (ch)
            0: ok = bus.aw_ready;
            1: ok = bus.w_ready;
            2: ok = bus.b_valid && bus.b_ready;
            3: ok = bus.ar_ready;
            default: ok = bus.r_valid && bus.r_ready && bus.r_last;
         endcase
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) fail_msg(name);
   endtask

   task automatic send_aw_w(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] data, input logic [7:0] strb, input bit push,
                            input logic [1:0] resp, input int evt);
      if (push) exp_b.push_back('{resp: resp, id: id});
      if (evt >= 0) exp_evt.push_back(4'(evt));
      bus.aw_valid = 1'b1;
      bus.aw_addr  = addr;
      bus.aw_id    = id;
      bus.aw_len   = len;
      wait_hs(0, "aw_timeout");
      bus.aw_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         bus.w_valid = 1'b1;
         bus.w_data  = data;
         bus.w_strb  = strb;
         bus.w_last  = (b == int'(len));
         wait_hs(1, "w_timeout");
      end
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [63:0] d0, input logic [1:0] resp0, input bit push);
      if (push) begin
         exp_r.push_back('{data: d0, resp: resp0, last: (len == 8'd0), id: id});
         for (int b = 1; b <= int'(len); b++)
            exp_r.push_back('{data: 64'h0, resp: 2'b10, last: (b == int'(len)), id: id});
      end
      bus.ar_valid = 1'b1;
      bus.ar_addr  = addr;
      bus.ar_id    = id;
      bus.ar_len   = len;
      wait_hs(3, "ar_timeout");
      bus.ar_valid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                     input logic [63:0] data, input logic [7:0] strb, input logic [1:0] resp,
                     input int evt);
      send_aw_w(addr, id, len, data, strb, 1'b1, resp, evt);
      wait_hs(2, "b_timeout");
   endtask

   task automatic rd(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                     input logic [63:0] d0, input logic [1:0] resp0);
      send_ar(addr, id, len, d0, resp0, 1'b1);
      wait_hs(4, "r_timeout");
   endtask

   task automatic wait_both_valid();
      for (int n = 0; n < 20 && !(bus.b_valid && bus.r_valid); n++) @(negedge clk);
      chk("both_valid", 64'(bus.b_valid && bus.r_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_id = '0; bus.aw_len = '0;
      bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0; bus.w_last = 1'b0;
      bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_id = '0; bus.ar_len = '0;
      bus.b_ready  = 1'b1; bus.r_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
      chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
      chk("rst_b", {bus.b_valid, bus.b_resp, bus.b_id}, 64'd0);
      chk("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
      chk("rst_r", {bus.r_valid, bus.r_resp, bus.r_last, bus.r_id}, 64'd0);
      chk("rst_r_data", bus.r_data, 64'd0);
      chk("rst_evt", {wr_evt, wr_idx}, 64'd0);
      @(posedge clk); #1;

      // Basic write/read
      wr(32'h10, 4'h5, 8'd0, 64'hDEADBEEF_01234567, 8'hFF, 2'b00, 2);
      rd(32'h10, 4'h3, 8'd0, 64'hDEADBEEF_01234567, 2'b00);
      // Partial strobe
      wr(32'h10, 4'h1, 8'd0, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 2'b00, 2);
      rd(32'h10, 4'h1, 8'd0, 64'hDEADBEEF_FFFFFFFF, 2'b00);
      // Out of range: no event, idx 0 alias untouched
      wr(32'h80, 4'h7, 8'd0, 64'h12345678_9ABCDEF0, 8'hFF, 2'b11, -1);
      rd(32'h80, 4'h2, 8'd0, 64'h0, 2'b11);
      rd(32'h00, 4'h2, 8'd0, 64'h0, 2'b00);
      // Bursts
      rd(32'h10, 4'h4, 8'd3, 64'h0, 2'b10);
      rd(32'h100, 4'h8, 8'd1, 64'h0, 2'b10);
      wr(32'h18, 4'h6, 8'd1, 64'hAAAAAAAA_AAAAAAAA, 8'hFF, 2'b10, -1);
      rd(32'h18, 4'h6, 8'd0, 64'h0, 2'b00);

      // Backpressure on B and R
      bus.b_ready = 1'b0;
      bus.r_ready = 1'b0;
      fork
         send_aw_w(32'h20, 4'h9, 8'd0, 64'h55555555_55555555, 8'hFF, 1'b1, 2'b00, 4);
         send_ar(32'h10, 4'hA, 8'd0, 64'hDEADBEEF_FFFFFFFF, 2'b00, 1'b1);
      join
      wait_both_valid();
      repeat (5) begin
         @(negedge clk);
         chk("bp_b", {bus.b_valid, bus.b_resp, bus.b_id, bus.aw_ready}, {58'd0, 1'b1, 2'b00, 4'h9, 1'b0});
         chk("bp_r_data", bus.r_data, 64'hDEADBEEF_FFFFFFFF);
         chk("bp_r", {bus.r_valid, bus.r_resp, bus.r_last, bus.r_id, bus.ar_ready},
             {56'd0, 1'b1, 2'b00, 1'b1, 4'hA, 1'b0});
      end
      @(posedge clk); #1;
      bus.b_ready = 1'b1;
      bus.r_ready = 1'b1;
      fork
         wait_hs(2, "bp_b_timeout");
         wait_hs(4, "bp_r_timeout");
      join
      rd(32'h20, 4'h3, 8'd0, 64'h55555555_55555555, 2'b00);

      // Write commits on the AR handshake edge: read sees the old word
      fork
         wr(32'h10, 4'h2, 8'd0, 64'h01234567_89ABCDEF, 8'hFF, 2'b00, 2);
         begin
            @(posedge clk); #1;
            rd(32'h10, 4'hB, 8'd0, 64'hDEADBEEF_FFFFFFFF, 2'b00);
         end
      join
      rd(32'h10, 4'hC, 8'd0, 64'h01234567_89ABCDEF, 2'b00);

      // Reset while both channels hold a pending response
      bus.b_ready = 1'b0;
      bus.r_ready = 1'b0;
      fork
         send_aw_w(32'h28, 4'h1, 8'd0, 64'h11112222_33334444, 8'hFF, 1'b0, 2'b00, 5);
         send_ar(32'h20, 4'h2, 8'd0, 64'h0, 2'b00, 1'b0);
      join
      wait_both_valid();
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("mid_rst_valids", {bus.b_valid, bus.r_valid, bus.w_ready}, 64'd0);
      chk("mid_rst_readys", {bus.aw_ready, bus.ar_ready}, 64'd3);
      chk("mid_rst_r_data", bus.r_data, 64'd0);
      @(posedge clk); #1;
      bus.b_ready = 1'b1;
      bus.r_ready = 1'b1;
      for (int i = 0; i < 16; i++)
         rd(32'(i * 8), 4'(i), 8'd0, 64'h0, 2'b00);

      repeat (3) @(posedge clk);
      chk("exp_b_drained", 64'(exp_b.size()), 64'd0);
      chk("exp_r_drained", 64'(exp_r.size()), 64'd0);
      chk("exp_evt_drained", 64'(exp_evt.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
